inst_rom_loader: RTL

- Byte-stream boot loader that writes the instruction memory of openmips_min_sopc from outside the core, replacing file preload.
- Accepts a framed byte stream over a valid/ready interface, assembles big-endian 32-bit words and issues one write per word into inst_rom.
- Holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.

---
 rtl/inst_rom_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/inst_rom_loader.sv
// Boot loader: takes a framed byte stream (length, big-endian words, XOR checksum),
// writes each word into inst_rom and keeps the CPU in reset until the image verifies.
module inst_rom_loader #(
    parameter int                 ADDR_W    = 32,
    parameter int unsigned        MAX_WORDS = 131071,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t              r_state;
    logic [1:0]          r_bcnt;
    logic [31:0]         r_wcnt;
    logic [31:0]         r_len;
    logic [31:0]         r_shift;
    logic [7:0]          r_xor;

    logic                w_acc;
    logic [31:0]         w_len_nxt;
    logic [31:0]         w_word;
    logic [ADDR_W-1:0]   w_waddr;

    assign w_acc     = in_valid && in_ready;
    assign w_len_nxt = {r_len[23:0], in_data};
    assign w_word    = {r_shift[23:0], in_data};
    // Word index counts from the frame start, so the address wraps naturally with ADDR_W.
    assign w_waddr   = BASE_ADDR + ADDR_W'({r_wcnt, 2'b00});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_LEN;
            r_bcnt       <= '0;
            r_wcnt       <= '0;
            r_len        <= '0;
            r_shift      <= '0;
            r_xor        <= '0;
            in_ready     <= 1'b0;
            rom_we       <= 1'b0;
            rom_addr     <= BASE_ADDR;
            rom_wdata    <= '0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            rom_we <= 1'b0;
            if (r_state inside {S_LEN, S_DATA, S_CSUM})
                in_ready <= 1'b1;
            case (r_state)
                S_LEN: if (w_acc) begin
                    r_len  <= w_len_nxt;
                    r_bcnt <= r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) begin
                        if (w_len_nxt > MAX_WORDS) begin
                            r_state  <= S_ERR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (w_len_nxt == '0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: if (w_acc) begin
                    r_shift <= w_word;
                    r_xor   <= r_xor ^ in_data;
                    r_bcnt  <= r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) begin
                        rom_we       <= 1'b1;
                        rom_addr     <= w_waddr;
                        rom_wdata    <= w_word;
                        words_loaded <= words_loaded + ADDR_W'(1);
                        r_wcnt       <= r_wcnt + 32'd1;
                        if (r_wcnt + 32'd1 == r_len)
                            r_state <= S_CSUM;
                    end
                end
                S_CSUM: if (w_acc) begin
                    in_ready <= 1'b0;
                    if (in_data == r_xor) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        r_state <= S_ERR;
                        error   <= 1'b1;
                    end
                end
                S_DONE, S_ERR: if (reload) begin
                    r_state      <= S_LEN;
                    r_bcnt       <= '0;
                    r_wcnt       <= '0;
                    r_len        <= '0;
                    r_shift      <= '0;
                    r_xor        <= '0;
                    in_ready     <= 1'b1;
                    rom_addr     <= BASE_ADDR;
                    cpu_rst      <= 1'b1;
                    done         <= 1'b0;
                    error        <= 1'b0;
                    words_loaded <= '0;
                end
                default: r_state <= S_LEN;
            endcase
        end
    end

endmodule
